// File: rtl/game_board_cell_writer.sv
// Sudoku board writer: loads a puzzle from a synchronous ROM, owns the cursor, applies edit commands.
// Optional macro SELECTION_WRAP_EN: cursor moves wrap at the board edge instead of saturating with a reject.
module game_board_cell_writer #(
  parameter int ROM_ADDR_W = 8,
  parameter int CELL_W     = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             is_game_on,
  input  logic [2:0]                       board_size,
  input  logic                             load_start,
  output logic [ROM_ADDR_W-1:0]            rom_addr,
  input  logic [4:0]                       rom_data,
  input  logic                             cmd_valid,
  input  logic [2:0]                       cmd_op,
  input  logic [4:0]                       cmd_digit,
  output logic [15:0][15:0][CELL_W-1:0]    board,
  output logic [3:0]                       selection_x,
  output logic [3:0]                       selection_y,
  output logic                             load_busy,
  output logic                             load_done,
  output logic                             cmd_reject
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t                state, state_next;
  logic                  start_load, wb_en, finish;
  logic [4:0]            n_cells, n_minus1, size_sq;
  logic [ROM_ADDR_W-1:0] wb_addr;
  logic [3:0]            wb_x, wb_y;
  logic [CELL_W-1:0]     wb_cell, cur_cell, cmd_cell;
  logic                  cmd_take, cmd_drop, cmd_wr, reject;
  logic [3:0]            sel_x_next, sel_y_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_load = 1'b0;
    wb_en      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_next = LOAD;
          start_load = 1'b1;
        end
      end
      LOAD: begin
        wb_en = (rom_addr != '0);
        if (rom_addr == '1) state_next = FLUSH;
      end
      FLUSH: begin
        wb_en      = 1'b1;
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Out-of-range block sizes clamp to the nearest legal size.
  always_comb begin
    case (board_size)
      3'd3:                    size_sq = 5'd9;
      3'd4, 3'd5, 3'd6, 3'd7:  size_sq = 5'd16;
      default:                 size_sq = 5'd4;
    endcase
  end

  // ROM data lags its address by one cycle; FLUSH holds the address at the last cell.
  assign wb_addr = (state == FLUSH) ? rom_addr : rom_addr - ROM_ADDR_W'(1);
  assign wb_y    = wb_addr[7:4];
  assign wb_x    = wb_addr[3:0];

  always_comb begin
    wb_cell = '0;
    if ({1'b0, wb_x} < n_cells && {1'b0, wb_y} < n_cells && rom_data != 5'd0)
      wb_cell = {rom_data, 1'b1};
  end

  assign cur_cell = board[selection_y][selection_x];
  assign n_minus1 = n_cells - 5'd1;
  assign cmd_take = cmd_valid && is_game_on && (state == IDLE) && !load_start;
  assign cmd_drop = cmd_valid && is_game_on && ((state != IDLE) || load_start);

  always_comb begin
    sel_x_next = selection_x;
    sel_y_next = selection_y;
    cmd_wr     = 1'b0;
    cmd_cell   = '0;
    reject     = cmd_drop;
    if (cmd_take) begin
      case (cmd_op)
        3'd0: begin
          if (selection_y == 4'd0) begin
`ifdef SELECTION_WRAP_EN
            sel_y_next = n_minus1[3:0];
`else
            reject = 1'b1;
`endif
          end else sel_y_next = selection_y - 4'd1;
        end
        3'd1: begin
          if ({1'b0, selection_y} == n_minus1) begin
`ifdef SELECTION_WRAP_EN
            sel_y_next = 4'd0;
`else
            reject = 1'b1;
`endif
          end else sel_y_next = selection_y + 4'd1;
        end
        3'd2: begin
          if (selection_x == 4'd0) begin
`ifdef SELECTION_WRAP_EN
            sel_x_next = n_minus1[3:0];
`else
            reject = 1'b1;
`endif
          end else sel_x_next = selection_x - 4'd1;
        end
        3'd3: begin
          if ({1'b0, selection_x} == n_minus1) begin
`ifdef SELECTION_WRAP_EN
            sel_x_next = 4'd0;
`else
            reject = 1'b1;
`endif
          end else sel_x_next = selection_x + 4'd1;
        end
        3'd4: begin
          if (cur_cell[0] || cmd_digit == 5'd0 || cmd_digit > n_cells) reject = 1'b1;
          else begin
            cmd_wr   = 1'b1;
            cmd_cell = {cmd_digit, 1'b0};
          end
        end
        3'd5: begin
          if (cur_cell[0]) reject = 1'b1;
          else             cmd_wr = 1'b1;
        end
        default: reject = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board       <= '0;
      selection_x <= 4'd0;
      selection_y <= 4'd0;
      rom_addr    <= '0;
      n_cells     <= 5'd4;
      load_busy   <= 1'b0;
      load_done   <= 1'b0;
      cmd_reject  <= 1'b0;
    end else begin
      load_done  <= finish;
      cmd_reject <= reject;
      if (start_load) begin
        n_cells     <= size_sq;
        rom_addr    <= '0;
        load_busy   <= 1'b1;
        selection_x <= 4'd0;
        selection_y <= 4'd0;
      end else if (state == LOAD && rom_addr != '1) begin
        rom_addr <= rom_addr + ROM_ADDR_W'(1);
      end
      if (finish) load_busy <= 1'b0;
      if (wb_en) board[wb_y][wb_x] <= wb_cell;
      if (cmd_take) begin
        selection_x <= sel_x_next;
        selection_y <= sel_y_next;
        if (cmd_wr) board[selection_y][selection_x] <= cmd_cell;
      end
    end
  end

endmodule

// File: tb/tb_game_board_cell_writer.sv
// Self-checking bench for game_board_cell_writer: directed steps plus random commands against a board model.
module tb_game_board_cell_writer;

  logic                     clk, rst, is_game_on, load_start, cmd_valid;
  logic [2:0]               board_size, cmd_op;
  logic [7:0]               rom_addr;
  logic [4:0]               rom_data, cmd_digit;
  logic [15:0][15:0][5:0]   board;
  logic [3:0]               selection_x, selection_y;
  logic                     load_busy, load_done, cmd_reject;

  logic [4:0] rom [256];
  int checks = 0;
  int errors = 0;

  int model_n, model_x, model_y;
  int model_val [16][16];
  bit model_lock [16][16];

  game_board_cell_writer dut (
    .clk(clk), .rst(rst), .is_game_on(is_game_on), .board_size(board_size),
    .load_start(load_start), .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_digit(cmd_digit),
    .board(board), .selection_x(selection_x), .selection_y(selection_y),
    .load_busy(load_busy), .load_done(load_done), .cmd_reject(cmd_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous puzzle ROM: data for an address appears the cycle after it.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task check_output(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function void model_reset();
    model_n = 4;
    model_x = 0;
    model_y = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        model_val[y][x]  = 0;
        model_lock[y][x] = 0;
      end
  endfunction

  function void model_load(input int bs);
    model_n = bs * bs;
    model_x = 0;
    model_y = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        int v;
        v = int'(rom[y * 16 + x]);
        if (x < model_n && y < model_n && v != 0) begin
          model_val[y][x]  = v;
          model_lock[y][x] = 1;
        end else begin
          model_val[y][x]  = 0;
          model_lock[y][x] = 0;
        end
      end
  endfunction

  // Returns whether the command should be refused, updating the model when it is accepted.
  function bit model_cmd(input int op, input int digit, input bit on);
    int nx, ny;
    if (!on) return 0;
    nx = model_x;
    ny = model_y;
    case (op)
      0: ny = model_y - 1;
      1: ny = model_y + 1;
      2: nx = model_x - 1;
      3: nx = model_x + 1;
      4: begin
        if (model_lock[model_y][model_x] || digit < 1 || digit > model_n) return 1;
        model_val[model_y][model_x] = digit;
        return 0;
      end
      5: begin
        if (model_lock[model_y][model_x]) return 1;
        model_val[model_y][model_x] = 0;
        return 0;
      end
      default: return 1;
    endcase
`ifdef SELECTION_WRAP_EN
    model_x = (nx + model_n) % model_n;
    model_y = (ny + model_n) % model_n;
    return 0;
`else
    if (nx < 0 || nx >= model_n || ny < 0 || ny >= model_n) return 1;
    model_x = nx;
    model_y = ny;
    return 0;
`endif
  endfunction

  function logic [95:0] model_row(input int y);
    logic [95:0] r;
    r = '0;
    for (int x = 0; x < 16; x++)
      r[x * 6 +: 6] = {5'(model_val[y][x]), model_lock[y][x]};
    return r;
  endfunction

  task check_board(input string tag);
    for (int y = 0; y < 16; y++)
      check_output($sformatf("%s_row%0d", tag, y), board[y], model_row(y));
  endtask

  task apply_stimulus(input int op, input int digit, input bit on);
    bit exp_rej;
    @(negedge clk);
    is_game_on = on;
    cmd_valid  = 1'b1;
    cmd_op     = 3'(op);
    cmd_digit  = 5'(digit);
    exp_rej    = model_cmd(op, digit, on);
    @(negedge clk);
    cmd_valid  = 1'b0;
    is_game_on = 1'b1;
    check_output($sformatf("reject_op%0d", op), cmd_reject, exp_rej);
    check_output("sel_x", selection_x, model_x);
    check_output("sel_y", selection_y, model_y);
    check_output("cursor_row", board[model_y], model_row(model_y));
  endtask

  task start_load(input int bs);
    @(negedge clk);
    board_size = 3'(bs);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task monitor_load(output int busy_cnt, output int done_cnt);
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      if (load_done) done_cnt++;
      if (!load_busy) break;
      busy_cnt++;
      @(negedge clk);
    end
    repeat (4) begin
      @(negedge clk);
      if (load_done) done_cnt++;
    end
  endtask

  initial begin
    int busy_cnt, done_cnt, bs, exp_x;
    for (int i = 0; i < 256; i++) rom[i] = 5'($urandom_range(0, 16));
    rom[0]              = 5'd5;
    rom[2]              = 5'd0;
    rom[1 * 16 + 2]     = 5'd0;
    rom[10 * 16 + 10]   = 5'd7;
    rst        = 1'b1;
    is_game_on = 1'b1;
    load_start = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 3'd0;
    cmd_digit  = 5'd0;
    board_size = 3'd2;
    model_reset();

    #3 rst = 1'b0;
    #3;
    check_board("reset");
    check_output("reset_busy", load_busy, 1'b0);
    check_output("reset_done", load_done, 1'b0);
    check_output("reset_reject", cmd_reject, 1'b0);
    check_output("reset_rom_addr", rom_addr, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("post_reset_sel_x", selection_x, 4'd0);
    check_output("post_reset_sel_y", selection_y, 4'd0);

    $display("[TB] directed load, board_size 3");
    start_load(3);
    monitor_load(busy_cnt, done_cnt);
    model_load(3);
    check_output("load_busy_cycles", busy_cnt, 257);
    check_output("load_done_pulses", done_cnt, 1);
    check_board("load3");
    check_output("cell_0_0", board[0][0], 6'b001011);
    check_output("cell_1_2", board[1][2], 6'd0);
    check_output("cell_10_10", board[10][10], 6'd0);

    $display("[TB] directed commands");
    apply_stimulus(4, 3, 1);
    check_output("locked_cell_kept", board[0][0], 6'b001011);
    apply_stimulus(3, 0, 1);
    apply_stimulus(3, 0, 1);
    apply_stimulus(4, 9, 1);
    check_output("write9_cell", board[0][2], 6'b010010);
    apply_stimulus(4, 10, 1);
    apply_stimulus(5, 0, 1);
    check_output("clear_cell", board[0][2], 6'd0);
    apply_stimulus(4, 1, 0);
    repeat (6) apply_stimulus(3, 0, 1);
    apply_stimulus(3, 0, 1);
`ifdef SELECTION_WRAP_EN
    exp_x = 0;
`else
    exp_x = 8;
`endif
    check_output("right_edge_x", selection_x, exp_x);
    apply_stimulus(0, 0, 1);
    apply_stimulus(6, 0, 1);

    $display("[TB] random load and commands");
    for (int i = 0; i < 256; i++) rom[i] = 5'($urandom_range(0, 16));
    bs = $urandom_range(2, 4);
    start_load(bs);
    monitor_load(busy_cnt, done_cnt);
    model_load(bs);
    check_output("rand_busy_cycles", busy_cnt, 257);
    check_output("rand_done_pulses", done_cnt, 1);
    check_board("rand_load");
    for (int i = 0; i < 300; i++)
      apply_stimulus($urandom_range(0, 7), $urandom_range(0, 20), ($urandom_range(0, 9) != 0));
    check_board("rand_cmds");

    $display("[TB] command during load");
    start_load(4);
    repeat (99) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    cmd_digit = 5'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("busy_cmd_reject", cmd_reject, 1'b1);
    monitor_load(busy_cnt, done_cnt);
    model_load(4);
    check_output("busy_cmd_load_ended", load_busy, 1'b0);
    check_output("busy_cmd_done_pulses", done_cnt, 1);
    check_board("busy_cmd");

    $display("[TB] reset mid-load");
    start_load(3);
    repeat (49) @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_output("midreset_busy", load_busy, 1'b0);
    check_board("midreset");
    check_output("midreset_sel_x", selection_x, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (load_done) done_cnt++;
    end
    check_output("midreset_no_done", done_cnt, 0);
    check_output("midreset_idle_busy", load_busy, 1'b0);
    apply_stimulus(4, 5, 1);
    apply_stimulus(4, 4, 1);
    check_output("reset_n4_write", board[0][0], 6'b001000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
